muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; the datapath is fixed at 32 bits.
REQ-002 Clk  input  1  rising-edge clock; all state changes on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  command strobe; sampled only when busy=0.
REQ-005 op  input  2  command: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-006 sign  input  1  1 = signed MULT/DIV, 0 = unsigned.
REQ-007 srca  input  32  operand A / dividend, fed from register file port outa.
REQ-008 srcb  input  32  operand B / divisor, fed from register file port outb.
REQ-009 busy  output  1  iterative operation in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 divzero  output  1  divide-by-zero flag, valid while done=1.
REQ-012 hi  output  32  HI register, driven directly from the register.
REQ-013 lo  output  32  LO register, driven directly from the register.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and FIX.
REQ-015 In IDLE with start=1 and op=MULT or DIV:
- latch operand magnitudes, op, sign and the zero-divisor condition;
- clear the iteration counter;
- go to RUN; busy=1 from the next cycle.
REQ-016 RUN SHALL perform exactly 32 iterations, one per cycle: shift-add for MULT (64-bit accumulator), restoring division for DIV (32-bit remainder/quotient). When counter=31, go to FIX.
REQ-017 FIX SHALL:
- apply sign correction;
- write hi/lo;
- pulse done=1 for the following cycle;
- return to IDLE with busy=0.
REQ-018 Latency: if start is accepted at edge E0, hi/lo update and done rises at edge E33. busy is high for exactly 33 cycles (E0..E33).
REQ-019 MULT SHALL produce {hi,lo} = the full 64-bit product of srca and srcb.
REQ-020 DIV SHALL produce lo=quotient and hi=remainder.
REQ-021 Signed DIV: the quotient is truncated toward zero; the remainder takes the dividend's sign.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-023 Signed MULT: the product is negated in FIX when operand signs differ.
REQ-024 DIV with srcb=0:
- run the full 33-cycle latency;
- leave hi/lo unchanged;
- assert divzero=1 together with done.
REQ-025 MTHI/MTLO accepted in IDLE: write srca to hi/lo at the accept edge; done=1 the next cycle; busy stays 0; divzero=0.
REQ-026 start while busy=1 SHALL be ignored, with no queuing and no effect on the running operation.
REQ-027 divzero SHALL be 0 whenever done=0.
REQ-028 hi/lo SHALL hold their values at all times except at FIX, MTHI/MTLO or Reset.

Reset
REQ-029 Reset=1 at a rising edge SHALL set state=IDLE, busy=0, done=0, divzero=0, hi=0, lo=0, and clear the counter.
REQ-030 Reset asserted mid-operation SHALL abort it: no done pulse and no partial hi/lo write.
REQ-031 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-032 Macro MULDIV_SIGNED_EN SHALL control signed support.
REQ-033 With MULDIV_SIGNED_EN defined: sign=1 selects signed MULT/DIV per REQ-021 to REQ-023.
REQ-034 Without MULDIV_SIGNED_EN:
- the sign port remains but is ignored;
- all MULT/DIV are unsigned;
- no sign-correction logic is present;
- latency is unchanged.

Verification
REQ-035 Unsigned MULT 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at E33, busy high 33 cycles.
REQ-036 Signed MULT -3 * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Without the macro, the same stimulus gives the unsigned product hi=0x00000006, lo=0xFFFFFFEB.
REQ-037 Unsigned DIV 100 / 7 -> lo=14, hi=2. Signed DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 Sequence: MTHI 0x1234; MTLO 0x5678; DIV 9 / 0 -> hi=0x1234, lo=0x5678 unchanged, divzero=1 for one cycle with done.
REQ-039 Reset during MULT at iteration 10 -> next cycle busy=0, hi=lo=0, and no done for the rest of the run.
REQ-040 A second start issued at E5 of a DIV -> ignored; a single done at E33 with the first operation's result.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Signed MULT/DIV is available only when MULDIV_SIGNED_EN is defined.
module muldiv_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        sign,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        busy,
  output logic        done,
  output logic        divzero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opb_q;
  logic        is_div_q;
  logic        dz_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q, divzero_q;

  logic        accept_iter;
  logic [32:0] madd;
  logic [32:0] dshift;
  logic [32:0] dsub;
  logic [63:0] acc_step;
  logic [31:0] res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  logic neg_q;
  logic negr_q;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic s);
    return (s && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic n);
    return n ? (~v + 64'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction
`else
  logic unused_sign;
  assign unused_sign = sign;
`endif

  assign accept_iter = (state_q == S_IDLE) && start && (op == OP_MULT || op == OP_DIV);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_iter) state_d = S_RUN;
      S_RUN:   if (cnt_q == 5'd31) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // One iteration: MULT adds the multiplicand into the upper half and shifts the
  // 64-bit accumulator right; DIV shifts {rem,quo} left and restores on borrow.
  always_comb begin
    madd   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    dshift = {acc_q[63:32], acc_q[31]};
    dsub   = dshift - {1'b0, opb_q};
    if (is_div_q) begin
      if (!dsub[32]) acc_step = {dsub[31:0], acc_q[30:0], 1'b1};
      else           acc_step = {dshift[31:0], acc_q[30:0], 1'b0};
    end else begin
      acc_step = {madd, acc_q[31:1]};
    end
  end

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    if (is_div_q) begin
      res_hi = neg32(acc_q[63:32], negr_q);
      res_lo = neg32(acc_q[31:0], neg_q);
    end else begin
      {res_hi, res_lo} = neg64(acc_q, neg_q);
    end
`else
    res_hi = acc_q[63:32];
    res_lo = acc_q[31:0];
`endif
  end

  // Operands are stored as magnitudes; the accumulator needs no reset since it
  // is always loaded at accept before being used.
  always_ff @(posedge Clk) begin
    if (accept_iter) begin
`ifdef MULDIV_SIGNED_EN
      acc_q  <= {32'd0, mag32(srca, sign)};
      opb_q  <= mag32(srcb, sign);
      neg_q  <= sign && (srca[31] ^ srcb[31]);
      negr_q <= sign && srca[31];
`else
      acc_q  <= {32'd0, srca};
      opb_q  <= srcb;
`endif
      is_div_q <= (op == OP_DIV);
      dz_q     <= (op == OP_DIV) && (srcb == 32'd0);
    end else if (state_q == S_RUN) begin
      acc_q <= acc_step;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= 5'd0;
          if (start && op == OP_MTHI) begin
            hi_q   <= srca;
            done_q <= 1'b1;
          end else if (start && op == OP_MTLO) begin
            lo_q   <= srca;
            done_q <= 1'b1;
          end
        end
        S_RUN: cnt_q <= cnt_q + 5'd1;
        S_FIX: begin
          done_q <= 1'b1;
          if (dz_q) begin
            divzero_q <= 1'b1;
          end else begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: cnt_q <= 5'd0;
      endcase
    end
  end

  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expectations follow
// MULDIV_SIGNED_EN the same way the design does.
module tb_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [1:0]  op;
  logic        sign;
  logic [31:0] srca, srcb;
  logic        busy, done, divzero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  muldiv_unit dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op), .sign(sign),
    .srca(srca), .srcb(srcb), .busy(busy), .done(done), .divzero(divzero),
    .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issues one command and follows it to done. restart_at > 0 raises start again
  // so that it is sampled at edge E<restart_at>.
  task automatic run_op(input logic [1:0] o, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int restart_at,
                        output int lat, output int busy_cnt, output logic dz,
                        output logic busy_at_done);
    start = 1'b1; op = o; sign = s; srca = a; srcb = b;
    tick();
    start = 1'b0;
    lat = 0; busy_cnt = 0; dz = 1'b0; busy_at_done = 1'b1;
    if (busy) busy_cnt++;
    while (!done && lat < 100) begin
      if (restart_at > 0 && lat == restart_at - 1) begin
        start = 1'b1; op = OP_MULT; sign = 1'b0; srca = 32'd5; srcb = 32'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (done) begin
        dz = divzero;
        busy_at_done = busy;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    start = 1'b0;
  endtask

  int   lat, bcnt, ndone;
  logic dz, bad;
  logic [63:0] exp64;

  initial begin
    Reset = 1'b1; start = 1'b1; op = OP_MTHI; sign = 1'b0;
    srca = 32'hDEAD_BEEF; srcb = 32'd0;
    tick();
    tick();
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_divzero", {63'd0, divzero}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    Reset = 1'b0; start = 1'b0;
    tick();

    run_op(OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt, dz, bad);
    chk("umul_ff_result", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    chk("umul_ff_latency", lat, 33);
    chk("umul_ff_busy_cycles", bcnt, 33);
    chk("umul_ff_busy_at_done", {63'd0, bad}, 64'd0);
    chk("umul_ff_divzero", {63'd0, dz}, 64'd0);
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);

    run_op(OP_MULT, 1'b0, 32'h1234_5678, 32'h0000_0010, 0, lat, bcnt, dz, bad);
    chk("umul_shift_result", {hi, lo}, 64'h0000_0001_2345_6780);

`ifdef MULDIV_SIGNED_EN
    exp64 = 64'hFFFF_FFFF_FFFF_FFEB;
`else
    exp64 = 64'h0000_0006_FFFF_FFEB;
`endif
    run_op(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, 0, lat, bcnt, dz, bad);
    chk("smul_m3x7_result", {hi, lo}, exp64);
    chk("smul_latency", lat, 33);

    run_op(OP_DIV, 1'b0, 32'd100, 32'd7, 0, lat, bcnt, dz, bad);
    chk("udiv_100_7", {hi, lo}, {32'd2, 32'd14});
    chk("udiv_latency", lat, 33);

`ifdef MULDIV_SIGNED_EN
    exp64 = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
`else
    exp64 = {32'h0000_0001, 32'h7FFF_FFFC};
`endif
    run_op(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt, dz, bad);
    chk("sdiv_m7_2", {hi, lo}, exp64);

`ifdef MULDIV_SIGNED_EN
    exp64 = {32'h0000_0000, 32'h8000_0000};
`else
    exp64 = {32'h8000_0000, 32'h0000_0000};
`endif
    run_op(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt, dz, bad);
    chk("sdiv_min_m1", {hi, lo}, exp64);

    start = 1'b1; op = OP_MTHI; srca = 32'h0000_1234;
    tick();
    start = 1'b0;
    chk("mthi_value", {32'd0, hi}, {32'd0, 32'h0000_1234});
    chk("mthi_done", {63'd0, done}, 64'd1);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    chk("mthi_divzero", {63'd0, divzero}, 64'd0);
    start = 1'b1; op = OP_MTLO; srca = 32'h0000_5678;
    tick();
    start = 1'b0;
    chk("mtlo_value", {32'd0, lo}, {32'd0, 32'h0000_5678});
    chk("mtlo_done", {63'd0, done}, 64'd1);
    tick();
    chk("mtlo_done_clears", {63'd0, done}, 64'd0);

    run_op(OP_DIV, 1'b0, 32'd9, 32'd0, 0, lat, bcnt, dz, bad);
    chk("div0_hilo_kept", {hi, lo}, {32'h0000_1234, 32'h0000_5678});
    chk("div0_divzero", {63'd0, dz}, 64'd1);
    chk("div0_latency", lat, 33);
    tick();
    chk("div0_divzero_clears", {63'd0, divzero}, 64'd0);

    run_op(OP_DIV, 1'b0, 32'd1000, 32'd10, 5, lat, bcnt, dz, bad);
    chk("restart_ignored_result", {hi, lo}, {32'd0, 32'd100});
    chk("restart_latency", lat, 33);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("restart_no_second_done", ndone, 0);

    start = 1'b1; op = OP_MULT; sign = 1'b0; srca = 32'hFFFF_FFFF; srcb = 32'h0000_0003;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_hilo_later", {hi, lo}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
